// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED
// controller that stops fetching on a halt word or an out-of-range PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_pcPlus1;
  logic        w_haltDetect;

  assign imem_addr    = r_pc;
  assign w_pcPlus1    = r_pc + 32'd1;
  assign w_haltDetect = (r_pc >= DEPTH_W) || (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_nextState;
  end

  // Redirect wakes a halted unit; a stalled RUN never evaluates the halt check.
  always_comb begin
    w_nextState = r_state;
    if (redirect)
      w_nextState = RUN;
    else if (r_state == RUN && !stall && w_haltDetect)
      w_nextState = HALTED;
  end

  always_comb begin
    halted = (r_state == HALTED);
  end

  // Priority: redirect > halted-hold > stall > halt detect > flush > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      ifid_instr    <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
      fetch_count   <= 32'd0;
    end else if (redirect) begin
      r_pc          <= redirect_target;
      ifid_instr    <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (r_state == HALTED || stall) begin
      r_pc          <= r_pc;
    end else if (w_haltDetect) begin
      ifid_instr    <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (flush) begin
      r_pc          <= w_pcPlus1;
      ifid_instr    <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else begin
      r_pc          <= w_pcPlus1;
      ifid_instr    <= imem_data;
      ifid_pc_plus1 <= w_pcPlus1;
      ifid_valid    <= 1'b1;
      fetch_count   <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0: word address loaded into PC on reset.
REQ-002 Parameter IMEM_DEPTH, default 128: number of instruction words; valid PCs are 0..IMEM_DEPTH-1.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: instruction encoding that halts fetch.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  hazard stall from decode; hold PC and IF/ID.
REQ-007 flush  in  1  squash the IF/ID load this cycle.
REQ-008 redirect  in  1  taken branch/jump from downstream.
REQ-009 redirect_target  in  32  new PC, word address.
REQ-010 imem_addr  out  32  word address to the instruction memory.
REQ-011 imem_data  in  32  instruction word, combinational from imem_addr within the same cycle.
REQ-012 ifid_instr  out  32  registered instruction to decode.
REQ-013 ifid_pc_plus1  out  32  registered PC+1 of that instruction.
REQ-014 ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
REQ-015 halted  out  1  fetch stopped (HALTED state).
REQ-016 fetch_count  out  32  count of valid instructions delivered to IF/ID.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; PC is a word address and increments by 1.
REQ-018 State machine SHALL have two states, RUN and HALTED; halted = (state == HALTED).
REQ-019 Per-edge priority in RUN SHALL be: rst > redirect > stall > halt detect > flush > normal.
REQ-020 Redirect (RUN or HALTED): PC <= redirect_target; IF/ID loads bubble (ifid_valid 0, ifid_instr 0, ifid_pc_plus1 0); state <= RUN; overrides stall and flush.
REQ-021 Stall without redirect: PC, IF/ID, fetch_count, and state SHALL hold unchanged.
REQ-022 Halt detect: in RUN with no redirect/stall, if PC >= IMEM_DEPTH or imem_data == HALT_WORD, then PC holds, IF/ID loads bubble, state <= HALTED.
REQ-023 Flush only (RUN, no redirect/stall/halt): PC <= PC+1; IF/ID loads bubble; fetch_count unchanged.
REQ-024 Normal: PC <= PC+1; ifid_instr <= imem_data; ifid_pc_plus1 <= PC+1; ifid_valid <= 1; fetch_count <= fetch_count+1.
REQ-025 HALTED without redirect: PC holds, IF/ID held as bubble, fetch_count holds; stall and flush are ignored.
REQ-026 PC+1 and fetch_count SHALL wrap modulo 2^32 without error.
REQ-027 Fetch latency: the instruction at address A SHALL appear in ifid_instr on the first edge after imem_addr = A with no stall.
REQ-028 A redirect to a target >= IMEM_DEPTH SHALL enter RUN, then halt on the next non-stalled edge per REQ-022.

Reset
REQ-029 On rst high at a rising edge: PC <= RESET_PC, ifid_instr <= 0, ifid_pc_plus1 <= 0, ifid_valid <= 0, fetch_count <= 0, state <= RUN; this overrides all other inputs, including mid-stall and HALTED.
REQ-030 While rst is high, imem_addr SHALL equal RESET_PC from the first edge onward.

Verification
REQ-031 Straight line: reset, memory words 0..3 = 0x11,0x22,0x33,0x44, no stall -> ifid_instr 0x11,0x22,0x33 on edges 1,2,3; ifid_pc_plus1 1,2,3; fetch_count 3.
REQ-032 Stall: stall high for 2 cycles while PC=2 -> imem_addr stays 2, ifid_instr and fetch_count frozen; resumes with word 2 next edge.
REQ-033 Redirect + stall same cycle, target 0x10 -> next edge PC=0x10, ifid_valid 0; following edge ifid_instr = mem[0x10], ifid_pc_plus1 0x11.
REQ-034 Halt: mem[5] = 0xFFFFFFFF -> after word 4 delivered, halted=1, PC stays 5, ifid_valid 0, fetch_count 5; later redirect to 0 restarts with halted=0.
REQ-035 Range: run off the end with IMEM_DEPTH=8 and no halt word -> PC holds at 8, halted=1, fetch_count 8.
REQ-036 Reset mid-operation: rst pulsed while HALTED and while stalled -> PC=RESET_PC, ifid_valid 0, fetch_count 0, halted 0 on that edge.
